// File: rtl/cmp_display_pkg.sv
// Shared constants for the comparator result display: result codes,
// active-low seven-segment glyphs {g,f,e,d,c,b,a} and the controller state type.
package cmp_display_pkg;

  localparam logic [7:0] CMP_GT = 8'h01;
  localparam logic [7:0] CMP_LT = 8'h02;
  localparam logic [7:0] CMP_EQ = 8'h03;

  localparam logic [6:0] GLYPH_A     = 7'b0001000;
  localparam logic [6:0] GLYPH_B     = 7'b0000011;
  localparam logic [6:0] GLYPH_GT    = 7'b0111001;
  localparam logic [6:0] GLYPH_LT    = 7'b0001111;
  localparam logic [6:0] GLYPH_EQ    = 7'b0110111;
  localparam logic [6:0] GLYPH_E     = 7'b0000110;
  localparam logic [6:0] GLYPH_R     = 7'b0101111;
  localparam logic [6:0] GLYPH_BLANK = 7'b1111111;

  typedef enum logic [1:0] {IDLE, LOAD, SHOW} state_t;

endpackage

// File: rtl/cmp_result_display_seg_scan.sv
// Digit multiplexer for a 4-digit display: a prescaler steps the digit index
// 3->2->1->0->3 every scan_div cycles while enabled.
module seg_scan #(
  parameter int SCAN_DIV = 50000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       restart,
  input  logic       enable,
  output logic [1:0] idx,
  output logic [3:0] an
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(SCAN_DIV - 1);

  logic [PW-1:0] pre;

  // restart gives the leftmost digit a full slot at the start of each display
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre <= '0;
      idx <= 2'd0;
    end else if (restart) begin
      pre <= '0;
      idx <= 2'd3;
    end else if (enable) begin
      if (pre == PRE_MAX) begin
        pre <= '0;
        idx <= idx - 2'd1;
      end else begin
        pre <= pre + 1'b1;
      end
    end
  end

  assign an = enable ? ~(4'b0001 << idx) : 4'b1111;

endmodule

// File: rtl/cmp_result_display.sv
// Accepts comparator result codes over valid/ready, decodes them into status
// flags and shows "A>b ", "A<b ", "A=b " or "Err " for a hold time.
module cmp_result_display
  import cmp_display_pkg::*;
#(
  parameter int SCAN_DIV    = 50000,
  parameter int HOLD_CYCLES = 100000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] code_in,
  input  logic       code_valid,
  output logic       code_ready,
  output logic       gt,
  output logic       lt,
  output logic       eq,
  output logic       err,
  output logic [6:0] seg,
  output logic [3:0] an
);

  localparam int HW = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;
  localparam logic [HW-1:0] HOLD_LOAD = (HOLD_CYCLES > 0) ? HW'(HOLD_CYCLES - 1) : '0;

  state_t        state;
  logic [7:0]    code_q;
  logic [HW-1:0] hold;
  logic          accept;
  logic [1:0]    idx;
  logic [6:0]    glyph;

  assign accept = code_valid && code_ready;

  // an accept takes priority over hold expiry and restarts the sequence
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      code_ready <= 1'b0;
      code_q     <= 8'h00;
      hold       <= '0;
      gt         <= 1'b0;
      lt         <= 1'b0;
      eq         <= 1'b0;
      err        <= 1'b0;
    end else if (accept) begin
      code_q     <= code_in;
      state      <= LOAD;
      code_ready <= 1'b0;
    end else begin
      case (state)
        IDLE: code_ready <= 1'b1;
        LOAD: begin
          gt         <= (code_q == CMP_GT);
          lt         <= (code_q == CMP_LT);
          eq         <= (code_q == CMP_EQ);
          err        <= !(code_q inside {CMP_GT, CMP_LT, CMP_EQ});
          hold       <= HOLD_LOAD;
          state      <= SHOW;
          code_ready <= 1'b1;
        end
        SHOW: begin
          if (HOLD_CYCLES != 0) begin
            if (hold == '0) state <= IDLE;
            else            hold  <= hold - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  seg_scan #(.SCAN_DIV(SCAN_DIV)) u_scan (
    .clk     (clk),
    .rst_n   (rst_n),
    .restart (state == LOAD),
    .enable  (state == SHOW),
    .idx     (idx),
    .an      (an)
  );

  always_comb begin
    glyph = GLYPH_BLANK;
    case (idx)
      2'd3: glyph = err ? GLYPH_E : GLYPH_A;
      2'd2: begin
        if (gt)      glyph = GLYPH_GT;
        else if (lt) glyph = GLYPH_LT;
        else if (eq) glyph = GLYPH_EQ;
        else         glyph = GLYPH_R;
      end
      2'd1: glyph = err ? GLYPH_R : GLYPH_B;
      default: glyph = GLYPH_BLANK;
    endcase
  end

  assign seg = (an == 4'b1111) ? GLYPH_BLANK : glyph;

endmodule
